pipe_hazard_ctrl: RTL

//  Parametrised hazard/forwarding/halt controller for the in-order RISC-V pipeline; generalises the fixed 5-stage controller.

---
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt controller for an in-order pipeline of NUM_STAGES stages.
// Tracks in-flight work from EX to the last stage and drives front-end enables and forwarding selects.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned EX_STAGE   = 2,
  parameter int unsigned LOAD_STAGE = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned FWD_W     = $clog2(NUM_STAGES - EX_STAGE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ext_stall,
  input  logic                        id_valid,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic                        id_wen,
  input  logic                        id_is_load,
  input  logic                        id_is_halt,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic                        ex_mispredict,
  output logic                        pc_en,
  output logic                        ifid_en,
  output logic                        ifid_flush,
  output logic                        idex_en,
  output logic                        idex_bubble,
  output logic [NUM_SRC*FWD_W-1:0]    fwd_sel,
  output logic                        halt_done,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt
);

  // Entry j holds the instruction in stage EX_STAGE+j.
  localparam int unsigned NE = NUM_STAGES - EX_STAGE;
  localparam int unsigned LU = LOAD_STAGE - EX_STAGE;

  logic                      v_q   [NE];
  logic [REG_AW-1:0]         rd_q  [NE];
  logic                      wen_q [NE];
  logic                      ld_q  [NE];
  logic                      hlt_q [NE];
  logic [NUM_SRC*REG_AW-1:0] ex_rs_q;
  logic [NUM_SRC-1:0]        ex_used_q;
  logic                      halt_pending_q;
  logic                      halt_latch_q;

  logic flush_c;
  logic loaduse_c;
  logic stall_c;

  // Load-use detection against loads whose data is not yet available.
  always_comb begin
    flush_c   = ex_mispredict & v_q[0] & ~ext_stall;
    loaduse_c = 1'b0;
    for (int j = 0; j < int'(LU); j++) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (id_valid && id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] != '0) &&
            v_q[j] && wen_q[j] && ld_q[j] && (rd_q[j] == id_rs[i*REG_AW +: REG_AW]))
          loaduse_c = 1'b1;
      end
    end
    stall_c = loaduse_c & ~flush_c & ~ext_stall;
  end

  assign pc_en       = ~ext_stall & ~stall_c & ~halt_pending_q;
  assign ifid_en     = ~ext_stall & ~stall_c;
  assign ifid_flush  = ~ext_stall & (flush_c | halt_pending_q);
  assign idex_en     = ~ext_stall;
  assign idex_bubble = stall_c | flush_c | halt_pending_q | ~id_valid;
  assign halt_done   = halt_latch_q | (v_q[NE-1] & hlt_q[NE-1]);

  // Youngest matching producer beyond EX supplies each EX operand.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      logic             found;
      logic [FWD_W-1:0] sel;
      found = 1'b0;
      sel   = '0;
      if (v_q[0] && ex_used_q[i] && (ex_rs_q[i*REG_AW +: REG_AW] != '0)) begin
        for (int j = 1; j < int'(NE); j++) begin
          if (!found && v_q[j] && wen_q[j] && (rd_q[j] == ex_rs_q[i*REG_AW +: REG_AW])) begin
            sel   = FWD_W'(j);
            found = 1'b1;
          end
        end
      end
      fwd_sel[i*FWD_W +: FWD_W] = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(NE); j++) begin
        v_q[j]   <= 1'b0;
        rd_q[j]  <= '0;
        wen_q[j] <= 1'b0;
        ld_q[j]  <= 1'b0;
        hlt_q[j] <= 1'b0;
      end
      ex_rs_q        <= '0;
      ex_used_q      <= '0;
      halt_pending_q <= 1'b0;
      halt_latch_q   <= 1'b0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      if (halt_done)
        halt_latch_q <= 1'b1;
      if (!ext_stall) begin
        for (int j = int'(NE) - 1; j > 0; j--) begin
          v_q[j]   <= v_q[j-1];
          rd_q[j]  <= rd_q[j-1];
          wen_q[j] <= wen_q[j-1];
          ld_q[j]  <= ld_q[j-1];
          hlt_q[j] <= hlt_q[j-1];
        end
        v_q[0]    <= ~idex_bubble;
        rd_q[0]   <= id_rd;
        wen_q[0]  <= id_wen;
        ld_q[0]   <= id_is_load;
        hlt_q[0]  <= id_is_halt;
        ex_rs_q   <= id_rs;
        ex_used_q <= id_rs_used;
        if (!idex_bubble && id_is_halt)
          halt_pending_q <= 1'b1;
        if (stall_c && (stall_cnt != '1))
          stall_cnt <= stall_cnt + CNT_W'(1);
        if (flush_c && (flush_cnt != '1))
          flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
